// File: rtl/cv32e41p_sequencer_pkg.sv
// Shared types, opcodes and RV32I encoders for the Zc push/pop sequencer.
package cv32e41p_sequencer_pkg;

   localparam int unsigned INSN_W  = 32;
   localparam int unsigned KIND_W  = 4;
   localparam int unsigned RLIST_W = 4;
   localparam int unsigned SPIMM_W = 5;
   localparam int unsigned REG_W   = 5;
   localparam int unsigned IMM_W   = 12;
   localparam int unsigned IDX_W   = 4;

   typedef logic [INSN_W-1:0]  insn_32_t;
   typedef logic [RLIST_W-1:0] rlist4_t;
   typedef logic [REG_W-1:0]   regnum_t;
   typedef logic [IMM_W-1:0]   imm12_t;

   typedef enum logic [KIND_W-1:0] {
      C_PUSH   = 4'd0,
      C_POP    = 4'd1,
      C_POPRET = 4'd2,
      C_TBLJ   = 4'd3,
      C_MVSA01 = 4'd4,
      C_MVA01S = 4'd5,
      PUSH     = 4'd6,
      POP      = 4'd7,
      POPRET   = 4'd8
   } instruction_e;

   typedef enum logic [1:0] {OP_PUSH, OP_POP, OP_POPRET} pp_op_e;

   typedef struct packed {
      pp_op_e               op;
      rlist4_t              rlist;
      logic [SPIMM_W-1:0]   spimm;
      logic                 retz;
   } pp_req_t;

   typedef enum logic [2:0] {IDLE, MEM, ADJ, RETZ, RET} pushpop_gen_state_e;

   localparam logic [6:0] OPC_STORE = 7'h23;
   localparam logic [6:0] OPC_LOAD  = 7'h03;
   localparam logic [6:0] OPC_OPIMM = 7'h13;
   localparam logic [6:0] OPC_JALR  = 7'h67;

   localparam regnum_t REG_ZERO = 5'd0;
   localparam regnum_t REG_RA   = 5'd1;
   localparam regnum_t REG_SP   = 5'd2;
   localparam regnum_t REG_A0   = 5'd10;

   // s0,s1 live at x8,x9; s2..s11 at x18..x27
   function automatic regnum_t sn_to_regnum(input logic [3:0] sn);
      return (sn < 4'd2) ? (REG_W'(sn) + 5'd8) : (REG_W'(sn) + 5'd16);
   endfunction

   function automatic imm12_t align_16(input imm12_t x);
      return (x + 12'd15) & 12'hFF0;
   endfunction

   function automatic insn_32_t enc_sw(input regnum_t rs2, input regnum_t rs1, input imm12_t imm);
      return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPC_STORE};
   endfunction

   function automatic insn_32_t enc_lw(input regnum_t rd, input regnum_t rs1, input imm12_t imm);
      return {imm, rs1, 3'b010, rd, OPC_LOAD};
   endfunction

   function automatic insn_32_t enc_addi(input regnum_t rd, input regnum_t rs1, input imm12_t imm);
      return {imm, rs1, 3'b000, rd, OPC_OPIMM};
   endfunction

   function automatic insn_32_t enc_jalr(input regnum_t rd, input regnum_t rs1, input imm12_t imm);
      return {imm, rs1, 3'b000, rd, OPC_JALR};
   endfunction

endpackage

// File: rtl/cv32e41p_pushpop_uop_enc.sv
// Combinational uop encoder: (state, idx, request) -> RV32I instruction word and last flag.
module cv32e41p_pushpop_uop_enc
   import cv32e41p_sequencer_pkg::*;
(
   input  pushpop_gen_state_e i_state,
   input  logic [IDX_W-1:0]   i_idx,
   input  pp_req_t            i_req,
   output insn_32_t           o_uop,
   output logic               o_last
);

   imm12_t  w_adj;
   imm12_t  w_off;
   regnum_t w_reg;

   always_comb begin
      w_adj  = align_16(IMM_W'(i_req.rlist) * 12'd4 + 12'd4) + (IMM_W'(i_req.spimm) << 4);
      w_off  = (IMM_W'(i_idx) + 12'd1) << 2;
      w_reg  = (i_idx == '0) ? REG_RA : sn_to_regnum(i_idx - IDX_W'(1));
      o_uop  = '0;
      o_last = 1'b0;
      case (i_state)
         MEM: begin
            if (i_req.op == OP_PUSH) o_uop = enc_sw(w_reg, REG_SP, 12'd0 - w_off);
            else                     o_uop = enc_lw(w_reg, REG_SP, w_adj - w_off);
         end
         ADJ: begin
            o_uop  = enc_addi(REG_SP, REG_SP, (i_req.op == OP_PUSH) ? (12'd0 - w_adj) : w_adj);
            o_last = (i_req.op != OP_POPRET);
         end
         RETZ: o_uop = enc_addi(REG_A0, REG_ZERO, '0);
         RET: begin
            o_uop  = enc_jalr(REG_ZERO, REG_RA, '0);
            o_last = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/cv32e41p_pushpop_uop_gen.sv
// Expands one Zc push/pop/popret request into its sw/lw/addi/jalr uop stream.
module cv32e41p_pushpop_uop_gen
   import cv32e41p_sequencer_pkg::*;
#(
   parameter int unsigned MAX_SREGS = 12
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               seq_valid_i,
   output logic               seq_ready_o,
   input  logic [KIND_W-1:0]  seq_kind_i,
   input  logic [RLIST_W-1:0] seq_rlist_i,
   input  logic [SPIMM_W-1:0] seq_spimm_i,
   input  logic               seq_retz_i,
   input  logic               kill_i,
   output logic [INSN_W-1:0]  uop_o,
   output logic               uop_valid_o,
   input  logic               uop_ready_i,
   output logic               uop_last_o,
   output logic               seq_illegal_o
);

   pushpop_gen_state_e r_state, w_state_nx;
   logic [IDX_W-1:0]   r_idx, w_idx_nx;
   pp_req_t            r_req, w_req_nx, w_in_req;
   logic               w_kind_ok, w_illegal_nx, w_fire, w_last;
   insn_32_t           w_uop;
   insn_32_t           r_uop;
   logic               r_valid, r_last, r_illegal, r_ready;

   // Map incoming kind to an internal op; anything else is illegal
   always_comb begin
      w_in_req.op    = OP_PUSH;
      w_in_req.rlist = seq_rlist_i;
      w_in_req.spimm = seq_spimm_i;
      w_in_req.retz  = seq_retz_i;
      w_kind_ok      = 1'b1;
      case (instruction_e'(seq_kind_i))
         C_PUSH, PUSH:     w_in_req.op = OP_PUSH;
         C_POP, POP:       w_in_req.op = OP_POP;
         C_POPRET, POPRET: w_in_req.op = OP_POPRET;
         default:          w_kind_ok   = 1'b0;
      endcase
   end

   assign w_fire = r_valid & uop_ready_i;

   always_comb begin
      w_state_nx   = r_state;
      w_idx_nx     = r_idx;
      w_req_nx     = r_req;
      w_illegal_nx = 1'b0;
      if (kill_i) begin
         w_state_nx = IDLE;
         w_idx_nx   = '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (seq_valid_i) begin
                  if (!w_kind_ok || (32'(seq_rlist_i) > MAX_SREGS)) begin
                     w_illegal_nx = 1'b1;
                  end else begin
                     w_state_nx = MEM;
                     w_idx_nx   = '0;
                     w_req_nx   = w_in_req;
                  end
               end
            end
            MEM: begin
               if (w_fire) begin
                  if (r_idx == r_req.rlist) begin
                     w_state_nx = ADJ;
                     w_idx_nx   = '0;
                  end else begin
                     w_idx_nx = r_idx + IDX_W'(1);
                  end
               end
            end
            ADJ: begin
               if (w_fire) begin
                  if (r_req.op != OP_POPRET) w_state_nx = IDLE;
                  else if (r_req.retz)       w_state_nx = RETZ;
                  else                       w_state_nx = RET;
               end
            end
            RETZ: if (w_fire) w_state_nx = RET;
            RET:  if (w_fire) w_state_nx = IDLE;
            default: w_state_nx = IDLE;
         endcase
      end
   end

   // Encoder looks at next-cycle state so uop_o can be registered
   cv32e41p_pushpop_uop_enc u_enc (
      .i_state (w_state_nx),
      .i_idx   (w_idx_nx),
      .i_req   (w_req_nx),
      .o_uop   (w_uop),
      .o_last  (w_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_idx     <= '0;
         r_req     <= '0;
         r_uop     <= '0;
         r_valid   <= 1'b0;
         r_last    <= 1'b0;
         r_illegal <= 1'b0;
         r_ready   <= 1'b1;
      end else begin
         r_state   <= w_state_nx;
         r_idx     <= w_idx_nx;
         r_req     <= w_req_nx;
         r_uop     <= w_uop;
         r_valid   <= (w_state_nx != IDLE);
         r_last    <= w_last;
         r_illegal <= w_illegal_nx;
         r_ready   <= (w_state_nx == IDLE);
      end
   end

   assign seq_ready_o   = r_ready;
   assign uop_o         = r_uop;
   assign uop_valid_o   = r_valid;
   assign uop_last_o    = r_last;
   assign seq_illegal_o = r_illegal;

endmodule
